// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store master: access sizes,
// response error codes, FSM states and the request legality check.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic [1:0] ERR_OK       = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0] ERR_SIZE     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   function automatic logic [1:0] req_check(
      input logic [1:0] size,
      input logic [1:0] addr
   );
      logic [1:0] err;
      err = ERR_OK;
      if (size == 2'd3)
         err = ERR_SIZE;
      else if (size == SZ_HALF && addr[0])
         err = ERR_MISALIGN;
      else if (size == SZ_WORD && addr != 2'b00)
         err = ERR_MISALIGN;
      return err;
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: byte enables, replicated store data and
// extracted/extended load data for one word-aligned access.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   input  logic        i_sign,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [31:0] w_bsh;
   logic [31:0] w_hsh;
   logic [7:0]  w_b;
   logic [15:0] w_h;

   assign w_bsh = i_rdata >> {i_addr, 3'b000};
   assign w_hsh = i_rdata >> {i_addr[1], 4'b0000};
   assign w_b   = w_bsh[7:0];
   assign w_h   = w_hsh[15:0];

   always_comb begin
      o_be    = 4'b0000;
      o_wdata = 32'h0;
      o_rdata = 32'h0;
      case (i_size)
         SZ_BYTE: begin
            o_be    = 4'b0001 << i_addr;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {{24{i_sign & w_b[7]}}, w_b};
         end
         SZ_HALF: begin
            o_be    = 4'b0011 << {i_addr[1], 1'b0};
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = {{16{i_sign & w_h[15]}}, w_h};
         end
         SZ_WORD: begin
            o_be    = 4'b1111;
            o_wdata = i_wdata;
            o_rdata = i_rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_master.sv
// Load/store initiator: one outstanding word-aligned memory access
// with a ready/rvalid handshake, timeout and load extension.
module lsu_master
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_sign,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [31:0]       req_pc,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic [1:0]        resp_err,
   output logic              stall,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic              r_sign;
   logic              r_we;
   logic [31:0]       r_wdata;
   logic [31:0]       r_pc;
   logic [1:0]        r_err;
   logic [31:0]       r_rdata;
   logic [CW-1:0]     r_cnt;

   logic [1:0]  w_chk;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_ext;
   logic [31:0] w_wmask;

   assign w_chk = req_check(req_size, req_addr[1:0]);

   lsu_lane u_lane (
      .i_size  (r_size),
      .i_addr  (r_addr[1:0]),
      .i_wdata (r_wdata),
      .i_rdata (mem_rdata),
      .i_sign  (r_sign),
      .o_be    (w_be),
      .o_wdata (w_wdata),
      .o_rdata (w_ext)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:
            if (req_valid)
               w_next = (w_chk == ERR_OK) ? ST_ISSUE : ST_RESP;
         ST_ISSUE:
            if (mem_ready)
               w_next = mem_rvalid ? ST_RESP : ST_WAIT;
         ST_WAIT:
            if (mem_rvalid || r_cnt == CNT_MAX)
               w_next = ST_RESP;
         default:
            w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr  <= '0;
         r_size  <= 2'b00;
         r_sign  <= 1'b0;
         r_we    <= 1'b0;
         r_wdata <= 32'h0;
         r_pc    <= 32'h0;
         r_err   <= ERR_OK;
         r_rdata <= 32'h0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE:
               if (req_valid) begin
                  r_addr  <= req_addr;
                  r_size  <= req_size;
                  r_sign  <= req_sign;
                  r_we    <= req_we;
                  r_wdata <= req_wdata;
                  r_pc    <= req_pc;
                  r_err   <= w_chk;
                  r_rdata <= 32'h0;
               end
            ST_ISSUE:
               if (mem_ready) begin
                  r_cnt <= '0;
                  if (mem_rvalid && !r_we)
                     r_rdata <= w_ext;
               end
            ST_WAIT:
               if (mem_rvalid) begin
                  if (!r_we)
                     r_rdata <= w_ext;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == CNT_MAX)
                     r_err <= ERR_TIMEOUT;
               end
            default: ;
         endcase
      end
   end

   assign req_ready  = (r_state == ST_IDLE);
   assign resp_valid = (r_state == ST_RESP);
   assign resp_err   = resp_valid ? r_err : ERR_OK;
   assign resp_rdata = resp_valid ? r_rdata : 32'h0;
   assign stall      = (req_valid & ~req_ready) | (r_state != ST_IDLE);

   // Command outputs are forced to zero outside ISSUE.
   assign mem_valid = (r_state == ST_ISSUE);
   assign mem_addr  = mem_valid ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
   assign mem_we    = mem_valid & r_we;
   assign mem_be    = mem_valid ? w_be : 4'b0000;
   assign mem_wdata = mem_valid ? w_wdata : 32'h0;

   always_comb begin
      w_wmask = r_wdata;
      case (r_size)
         SZ_BYTE: w_wmask = {24'h0, r_wdata[7:0]};
         SZ_HALF: w_wmask = {16'h0, r_wdata[15:0]};
         default: ;
      endcase
   end

`ifndef SYNTHESIS
   always @(posedge clk)
      if (reset && r_state == ST_ISSUE && mem_ready && r_we)
         $display("@%h: *%h <= %h", r_pc, r_addr, w_wmask);
`endif

endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- Load/store initiator between the CPU MEM stage and a word-organised data memory with a variable-latency handshake.
- Accepts one load or store per request: word, half or byte, with signed or unsigned loads.
- For each request it drives a word-aligned memory access with byte enables, lane-shifted write data, and a wait/timeout FSM.
- Returns the extracted, extended load data, or an error. It stalls the pipeline until the access completes.

Parameters:
- TIMEOUT, 16, max cycles waiting for mem_rvalid after issue before a bus error (>=2).
- ADDR_W, 32, byte address width on both sides.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  1  CPU request present
- req_ready  out  1  block can accept a request (state IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_sign  in  1  loads: 1 = sign-extend, 0 = zero-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- req_pc  in  32  PC of the instruction, for the store trace
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_err  out  2  0 = ok, 1 = misaligned, 2 = timeout, 3 = bad size
- stall  out  1  pipeline hold: req_valid & ~req_ready, or state != IDLE
- mem_valid  out  1  memory command valid
- mem_ready  in  1  memory accepts the command
- mem_addr  out  ADDR_W  {req_addr[ADDR_W-1:2], 2'b00}
- mem_we  out  1  write command
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- mem_wdata  out  32  lane-aligned write data
- mem_rvalid  in  1  read data / write ack valid
- mem_rdata  in  32  full word read

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0 except req_ready=1; timeout counter 0. A mid-transaction reset abandons the access with no resp_valid.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: on req_valid, register addr/size/sign/we/wdata/pc.
  - Legality check: size 3 -> err 3; half with addr[0]=1 -> err 1; word with addr[1:0]!=0 -> err 1.
  - Illegal request -> RESP with the error; no memory command is issued.
  - Legal request -> ISSUE.
- ISSUE: mem_valid=1; addr/we/be/wdata held stable until mem_ready=1.
  - On mem_ready -> WAIT, counter cleared.
  - If mem_ready and mem_rvalid arrive in the same cycle, go directly to RESP.
- WAIT: counter increments each cycle.
  - On mem_rvalid -> RESP and latch the result.
  - When counter reaches TIMEOUT-1 without mem_rvalid -> RESP with err 2. A later stray mem_rvalid is ignored.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready is 1 only in IDLE.
- Minimum latency for a legal access with a zero-wait memory: accept at cycle 0, resp_valid at cycle 2.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Write data: the byte or half is replicated across all lanes (byte x4, half x2); word passes through unchanged. Memory merges using mem_be.
- Load extract:
  - byte: lane = mem_rdata >> {addr[1:0],3'b000}, bits [7:0].
  - half: bits [15:0] of mem_rdata >> {addr[1],4'b0000}.
  - Extended to 32 bits per req_sign.
- resp_rdata is registered, valid only with resp_valid, and 0 for stores and errors.
- Store trace: on store acceptance by memory, $display("@%h: *%h <= %h", pc, byte addr, req_wdata masked to size).
- Invariant: at most one outstanding transaction; req_valid is ignored outside IDLE.

Decomposition:
- Package lsu_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), error codes (ERR_OK/ERR_MISALIGN/ERR_TIMEOUT/ERR_SIZE), state enum.
- Sub-module lsu_lane, purely combinational:
  - inputs size, addr[1:0], wdata, rdata, sign
  - outputs be, lane wdata, extended rdata
  - testable stand-alone.

Test Plan:
- Store word 0x12345678 to 0x0000_1004, memory with 0 waits -> mem_be=1111, mem_addr=0x1004, resp_valid at cycle 2, resp_err=0.
- Store byte 0xAB to 0x1003 -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000.
- Load half signed from 0x1002, mem_rdata=0x8001_7FFF -> resp_rdata=0xFFFF8001. Unsigned byte from 0x1001 -> 0x0000007F.
- Load word from 0x1006 -> no mem_valid; resp_valid next cycle+1 with err 1. Size 3 -> err 3.
- mem_ready held low 5 cycles, then mem_rvalid after 3 more -> command stable throughout, stall=1, single resp_valid.
- mem_rvalid never asserted with TIMEOUT=16 -> err 2 after 16 WAIT cycles. Reset asserted in WAIT -> immediate IDLE, req_ready=1, no resp_valid.
